// File: rtl/dmem_pkg.sv
// Shared constants and FSM state type for the dmem_resp data-memory responder.
package dmem_pkg;

    localparam int DATA_W          = 32;
    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_resp: one synchronous write port, one combinational read port,
// every word cleared by the asynchronous active-low reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int IDX_W = DEF_ADDR_W - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_CYCLES wait states,
// then holds the response until consumed. Optional alignment check: DMEM_RESP_ALIGN_CHECK_EN.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              accept;
    logic              enter_resp;
    logic              consume;
    logic              misalign;
    logic              mem_we;
    logic              eff_we;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] eff_wdata;
    logic [DATA_W-1:0] mem_rdata;

    assign accept  = req_valid && (state_q == IDLE);
    assign consume = (state_q == RESP) && rsp_ready;

    // With zero wait states RESP is entered on the accept edge itself, so the live
    // request fields are used instead of the not-yet-captured copies.
    assign eff_we    = (state_q == IDLE) ? req_we    : we_q;
    assign eff_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign eff_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    assign mem_we     = enter_resp && eff_we && !misalign;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (enter_resp) begin
            rdata_d = (eff_we || misalign) ? '0 : mem_rdata;
        end else if (consume) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

`ifdef DMEM_RESP_ALIGN_CHECK_EN
    logic err_q, err_d;

    assign misalign = (eff_addr[1:0] != 2'b00);

    always_comb begin
        err_d = err_q;
        if (enter_resp) begin
            err_d = misalign;
        end else if (consume) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    logic unused_addr_lsb;

    assign misalign        = 1'b0;
    assign unused_addr_lsb = ^eff_addr[1:0];
    assign rsp_err         = 1'b0;
`endif

    dmem_array #(
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst),
        .we_i    (mem_we),
        .waddr_i (eff_addr[ADDR_W-1:2]),
        .wdata_i (eff_wdata),
        .raddr_i (eff_addr[ADDR_W-1:2]),
        .rdata_o (mem_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance,
// randomized traffic compared against a word-array reference model.
module tb_dmem_resp;

    localparam int WAITC = 2;
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with two wait states
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Instance with zero wait states
    logic        rst0 = 1'b0;
    logic        v0 = 1'b0;
    logic        we0 = 1'b0;
    logic [9:0]  a0 = '0;
    logic [31:0] wd0 = '0;
    logic        qr0;
    logic        sv0;
    logic        rr0 = 1'b1;
    logic [31:0] rd0;
    logic        er0;

    int nvec  = 0;
    int nfail = 0;

    logic [31:0] mdl_mem  [256];
    logic [31:0] mdl0_mem [256];

    dmem_resp #(.ADDR_W(10), .WAIT_CYCLES(WAITC)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    dmem_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst       (rst0),
        .req_valid (v0),
        .req_we    (we0),
        .req_addr  (a0),
        .req_wdata (wd0),
        .req_ready (qr0),
        .rsp_valid (sv0),
        .rsp_ready (rr0),
        .rsp_rdata (rd0),
        .rsp_err   (er0)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: the memory is an array of words indexed by byte address / 4.
    task automatic model_apply(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                               output logic [31:0] rd, output logic err);
        int idx;
        idx = int'(addr) / 4;
        err = ALIGN_CHK && ((int'(addr) % 4) != 0);
        rd  = 32'h0;
        if (!err) begin
            if (we) mdl_mem[idx] = wd;
            else    rd = mdl_mem[idx];
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mdl_mem[i] = 32'h0;
    endtask

    task automatic do_txn(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                          input int stall, input string name);
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        zero_ok;
        int          e;
        int          guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!req_ready) begin
            nvec++; nfail++;
            $display("FAIL %s: req_ready timeout, got %b want 1", name, req_ready);
            return;
        end
        model_apply(we, addr, wd, exp_rd, exp_err);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        rsp_ready = (stall == 0);
        @(posedge clk); #1;
        // Inputs change after accept; the transaction must not see them.
        req_valid = 1'b0; req_we = $urandom; req_addr = 10'($urandom); req_wdata = $urandom;
        e = 1;
        zero_ok = 1'b1;
        while (!rsp_valid && e < 20) begin
            if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) zero_ok = 1'b0;
            @(posedge clk); #1;
            e++;
        end
        nvec++;
        if (!rsp_valid || e != WAITC + 1) begin
            nfail++;
            $display("FAIL %s latency: rsp_valid first seen at edge +%0d (valid=%b), want +%0d",
                     name, e, rsp_valid, WAITC + 1);
            rsp_ready = 1'b1;
            return;
        end
        nvec++;
        if (zero_ok !== 1'b1) begin
            nfail++;
            $display("FAIL %s idle outputs: rdata/err nonzero before response", name);
        end
        nvec++;
        if (rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
            nfail++;
            $display("FAIL %s data: got rdata=%h err=%b want rdata=%h err=%b",
                     name, rsp_rdata, rsp_err, exp_rd, exp_err);
        end
        for (int s = 0; s < stall; s++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            nvec++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
                nfail++;
                $display("FAIL %s stall%0d: got valid=%b ready=%b rdata=%h err=%b want 1 0 %h %b",
                         name, s, rsp_valid, req_ready, rsp_rdata, rsp_err, exp_rd, exp_err);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        nvec++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            nfail++;
            $display("FAIL %s consume: got valid=%b ready=%b rdata=%h err=%b want 0 1 0 0",
                     name, rsp_valid, req_ready, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        nvec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            nfail++;
            $display("FAIL reset_state: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) do_txn(1'b0, {8'($urandom), 2'b00}, 32'h0, 0, "reset_load");
    endtask

    task automatic test_store_load();
        do_txn(1'b1, 10'h010, 32'hDEAD_BEEF, 0, "store_0x10");
        do_txn(1'b0, 10'h010, 32'h0, 0, "load_0x10");
    endtask

    task automatic test_backpressure();
        do_txn(1'b1, 10'h040, 32'hA5A5_0F0F, 0, "bp_store");
        do_txn(1'b0, 10'h040, 32'h0, 5, "bp_load");
    endtask

    task automatic test_misaligned();
        do_txn(1'b1, 10'h010, 32'h1111_2222, 0, "mis_prior");
        do_txn(1'b1, 10'h012, 32'h3333_4444, 0, "mis_store");
        do_txn(1'b0, 10'h010, 32'h0, 0, "mis_load");
    endtask

    task automatic test_reset_mid();
        do_txn(1'b1, 10'h024, 32'hCAFE_F00D, 0, "rm_prefill");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h020; req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        nvec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            nfail++;
            $display("FAIL reset_mid: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        #2;
        rst = 1'b1;
        model_clear();
        do_txn(1'b0, 10'h020, 32'h0, 0, "rm_load_0x20");
        do_txn(1'b0, 10'h024, 32'h0, 0, "rm_load_0x24");
    endtask

    task automatic test_wrap();
        do_txn(1'b1, 10'h000, 32'h0BAD_0000, 0, "wrap_word0");
        do_txn(1'b1, 10'h3FC, 32'h7777_8888, 1, "wrap_store");
        do_txn(1'b0, 10'h3FC, 32'h0, 0, "wrap_load");
        do_txn(1'b0, 10'h000, 32'h0, 0, "wrap_word0_load");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [9:0] a;
            a = {5'd0, 3'($urandom), 2'($urandom)};
            do_txn(1'($urandom), a, $urandom, int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_q[$];
        int          last_acc;
        logic [31:0] r;
        for (int i = 0; i < 256; i++) mdl0_mem[i] = 32'h0;
        last_acc = -10;
        v0 = 1'b1; rr0 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c == 0) begin
                we0 = 1'b0; a0 = 10'h000; wd0 = $urandom;
            end else begin
                we0 = $urandom; a0 = {5'd0, 3'($urandom), 2'b00}; wd0 = $urandom;
            end
            nvec++;
            if (sv0 !== (last_acc == c - 1)) begin
                nfail++;
                $display("FAIL zw_valid cyc%0d: got %b want %b", c, sv0, (last_acc == c - 1));
            end
            if (sv0 && exp_q.size() > 0) begin
                r = exp_q.pop_front();
                nvec++;
                if (rd0 !== r || er0 !== 1'b0) begin
                    nfail++;
                    $display("FAIL zw_data cyc%0d: got rdata=%h err=%b want %h 0", c, rd0, er0, r);
                end
            end
            if (qr0) begin
                if (last_acc >= 0) begin
                    nvec++;
                    if (c - last_acc != 2) begin
                        nfail++;
                        $display("FAIL zw_spacing: got %0d cycles want 2", c - last_acc);
                    end
                end
                last_acc = c;
                if (we0) begin
                    mdl0_mem[int'(a0) / 4] = wd0;
                    exp_q.push_back(32'h0);
                end else begin
                    exp_q.push_back(mdl0_mem[int'(a0) / 4]);
                end
            end
            @(posedge clk); #1;
        end
        v0 = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b1;
        test_reset();
        test_store_load();
        test_backpressure();
        test_misaligned();
        test_wrap();
        test_random();
        test_reset_mid();
        test_zero_wait();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
